muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer sitting beside the execute-stage ALU. It accepts one M-extension operation from the execute stage and runs it over 32 iteration cycles on a single shared 33-bit add/subtract datapath. While it runs, it stalls the front of the pipeline, then presents a registered 32-bit result for one cycle so the execute/memory pipeline register can capture it in place of the ALU output.

---
 rtl/muldiv_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide on one shared 33-bit adder: 33-cycle latency, 1 cycle on fast paths.
// Define MULDIV_DIV_EN to build divide/remainder; otherwise divide ops complete at once with result 0.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W = XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t       state_q;
  logic [2:0]   f3_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic [W-1:0] opb_q;
  logic [W-1:0] result_q;
  logic         neg_q_q;
`ifdef MULDIV_DIV_EN
  logic         neg_r_q;
`endif
  logic [5:0]   cnt_q;
  logic         done_q;

  logic         a_signed;
  logic         b_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & op1[W-1];
    b_neg    = b_signed & op2[W-1];
    a_mag    = a_neg ? (~op1 + 1'b1) : op1;
    b_mag    = b_neg ? (~op2 + 1'b1) : op2;
  end

  logic         fast;
  logic [W-1:0] fast_res;

`ifdef MULDIV_DIV_EN
  logic div_zero;
  logic div_ovf;

  always_comb begin
    div_zero = funct3[2] && (op2 == '0);
    div_ovf  = funct3[2] && !funct3[0] &&
               (op1 == {1'b1, {(W-1){1'b0}}}) && (op2 == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) begin
      fast_res = funct3[1] ? op1 : '1;
    end else if (div_ovf) begin
      fast_res = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end else begin
      fast_res = '0;
    end
  end
`else
  assign fast     = funct3[2];
  assign fast_res = '0;
`endif

  // Shared adder: multiply accumulates hi + multiplicand, divide subtracts divisor.
  logic [W:0] add_a;
  logic [W:0] add_b;
  logic [W:0] add_s;
  logic       add_cin;

  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = lo_q[0] ? {1'b0, opb_q} : '0;
    add_cin = 1'b0;
`ifdef MULDIV_DIV_EN
    if (f3_q[2]) begin
      add_a   = {hi_q, lo_q[W-1]};
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end
`endif
  end

  assign add_s = add_a + add_b + {{W{1'b0}}, add_cin};

  logic [W-1:0] hi_n;
  logic [W-1:0] lo_n;
`ifdef MULDIV_DIV_EN
  logic         div_ge;
`endif

  always_comb begin
    hi_n = add_s[W:1];
    lo_n = {add_s[0], lo_q[W-1:1]};
`ifdef MULDIV_DIV_EN
    // Shifted remainder with top bit set always exceeds a W-bit divisor.
    div_ge = add_a[W] | ~add_s[W];
    if (f3_q[2]) begin
      hi_n = div_ge ? add_s[W-1:0] : add_a[W-1:0];
      lo_n = {lo_q[W-2:0], div_ge};
    end
`endif
  end

  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   final_res;

  always_comb begin
    prod     = {hi_n, lo_n};
    prod_fix = neg_q_q ? (~prod + 1'b1) : prod;
    case (f3_q)
      3'b000:                 final_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*W-1:W];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         final_res = neg_q_q ? (~lo_n + 1'b1) : lo_n;
      default:                final_res = neg_r_q ? (~hi_n + 1'b1) : hi_n;
`else
      default:                final_res = '0;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      neg_q_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r_q  <= 1'b0;
`endif
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            f3_q <= funct3;
            if (fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= funct3[2] ? a_mag : b_mag;
              opb_q   <= funct3[2] ? b_mag : a_mag;
              neg_q_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
              neg_r_q <= a_neg;
`endif
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(W-1)) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
  assign done   = done_q;
  assign result = result_q;

endmodule
